seven_segment_display_driver: RTL and testbench
===============================================

# seven_segment_display_driver

Parametrised multi-digit hexadecimal display driver: latches a NUM_DIGITS×4-bit value on a load strobe and decodes each nibble to active-low 7-segment patterns. It adds optional leading-zero blanking, per-digit blinking and a global enable. It provides two registered output forms: per-digit static segment outputs for boards with direct-wired displays, and a time-multiplexed scan output (segment bus plus active-low digit select) for boards with shared-segment displays. It sits at the top level beside the processor, displaying debug or register values.

## Interface
- NUM_DIGITS, 6: number of hex digits. Legal range 1..8.
- SCAN_DIV, 50000: clock cycles each digit is held on the scan output. Minimum 1.
- BLINK_DIV, 25000000: clock cycles per blink half-period. Minimum 1.
- clk  input  1  system clock. One clock domain only.
- rst  input  1  reset, synchronous, active-high.
- load  input  1  when high, latch data, lz_blank and blink_mask at the rising edge.
- data  input  4*NUM_DIGITS  value; digit i = data[4i+3:4i], digit 0 is rightmost.
- lz_blank  input  1  leading-zero blanking mode (latched with load).
- blink_mask  input  NUM_DIGITS  per-digit blink enable (latched with load).
- en  input  1  live, not latched; 0 blanks all outputs.
- hex_out  output  7*NUM_DIGITS  static active-low segments; digit i at [7i+6:7i]. Bit order {g,f,e,d,c,b,a}.
- scan_seg  output  7  active-low segments of the currently selected digit.
- scan_an  output  NUM_DIGITS  active-low one-hot digit select.

## Operation
- Registers:
  - value_q, lz_q and blink_q are loaded only when load=1.
  - scan_cnt and scan_idx drive the scanner.
  - blink_cnt and blink_ph drive blinking.
- Decode (7-bit hex, active-low):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
  - Blank = 7F.
- Leading-zero blanking (lz_q=1): digit i is blanked if every nibble at index ≥i is 0. Digit 0 is never blanked by this rule, so value 0 shows "0".
- Blink:
  - blink_cnt counts 0..BLINK_DIV-1 and wraps; blink_ph toggles on each wrap.
  - While blink_ph=1, every digit with blink_q[i]=1 is blank.
- Enable: en=0 forces every hex_out digit, scan_seg and scan_an to all-ones. Both counters keep running.
- Digit is visible when: en=1, it is not leading-zero blanked, and it is not in the blink-off phase.
- Scanner:
  - scan_cnt counts 0..SCAN_DIV-1; on wrap, scan_idx advances and wraps from NUM_DIGITS-1 to 0.
  - scan_an[scan_idx]=0 and all other bits are 1.
  - scan_seg is the visible pattern of digit scan_idx.
  - With NUM_DIGITS=1, scan_idx stays at 0.
- Load does not reset the scanner or blink counters or phase.
- Load asserted on consecutive cycles: the last value wins.

## Timing
- Reset values:
  - value_q=0, lz_q=0, blink_q=0.
  - Counters 0, scan_idx=0, blink_ph=0.
  - hex_out all 7F, scan_seg=7F, scan_an all ones.
- Reset takes priority over load in the same cycle.
- Reset mid-operation discards the latched value and restarts both counters from 0.
- Latency:
  - Load sampled at edge k updates value_q at edge k.
  - hex_out and scan_seg reflect the new value at edge k+1 (two edges from load presentation).
- en also acts through the output register, so it takes one edge to affect the outputs.
- scan_an and scan_seg change together, on the same edge, one edge after scan_idx advances. There is never a cycle where the select and segment data mismatch.
- Blink visibility changes one edge after the blink_ph toggle.
- Scan period is SCAN_DIV×NUM_DIGITS cycles; blink period is 2×BLINK_DIV cycles.
- Counter widths are $clog2 of the divisor, with a minimum of 1 bit.

## Structure
- Package seven_seg_pkg holds:
  - seg_t, the 7-bit segment typedef;
  - the SEG_BLANK constant (7'h7F);
  - the hex-to-segment constant table.
- Sub-module hex_digit_decoder: combinational 4-bit→seg_t decoder, instantiated NUM_DIGITS times via generate.
- Top level holds all registers, the blanking logic, the scan mux and the output registers.

## Test plan
Bench uses NUM_DIGITS=4, SCAN_DIV=4, BLINK_DIV=8.
- Reset, then load data=16'h1234 with en=1:
  - hex_out = {79,24,30,19} (digit3..0) two edges after load;
  - before that, hex_out = all 7F.
- Load 16'h00A0 with lz_blank=1 → digits 3 and 2 are 7F, digit 1 is 08, digit 0 is 40. Load 16'h0000 → only digit 0 shows 40.
- Scan:
  - scan_an cycles E, D, B, 7 (digits 0..3), holding each for 4 cycles, then wraps back to E;
  - scan_seg matches the selected digit on every cycle.
- Load blink_mask=4'b0001 → digit 0 alternates between its pattern and 7F every 8 cycles; other digits are steady.
- Drive en=0 mid-scan → all outputs are all-ones after one edge. Return en to 1 → the scan resumes at the scan_idx reached by the still-running counter.
- Assert rst together with load=1 of 16'hFFFF → all outputs are blank and value_q=0. With en=1 after release, the digits show 40 (no leading-zero blanking).

Source files
------------

// File: rtl/seven_seg_pkg.sv
// ---------------------------------------------------------------------------
// seven_seg_pkg
//   Shared types and constants for the seven-segment display driver.
//   - seg_t          : one active-low segment pattern, bit order {g,f,e,d,c,b,a}
//   - SEG_BLANK      : all segments off (active-low, so all ones)
//   - HEX_SEG_TABLE  : hex nibble -> segment pattern, indexed by the nibble
//   - hex_to_seg()   : table lookup helper
//   - cnt_width()    : counter width for a divisor, never below one bit
// ---------------------------------------------------------------------------
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Packed table, element 15 leftmost so HEX_SEG_TABLE[n] is the glyph for n.
  // Glyphs: 0 1 2 3 4 5 6 7 8 9 A b C d E F
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  function automatic seg_t hex_to_seg(input logic [3:0] nib);
    return HEX_SEG_TABLE[nib];
  endfunction

  // A divisor of 1 would give $clog2 = 0; keep at least one bit so the
  // counter still exists (it simply stays at zero and wraps every cycle).
  function automatic int cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/hex_digit_decoder.sv
// ---------------------------------------------------------------------------
// hex_digit_decoder
//   Purely combinational 4-bit hex nibble to active-low 7-segment decoder.
//   Ports:
//     nibble : input  4-bit hex digit value
//     seg    : output active-low segment pattern {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module hex_digit_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seven_segment_display_driver.sv
// ---------------------------------------------------------------------------
// seven_segment_display_driver
//   Multi-digit hex display driver. Latches a NUM_DIGITS x 4-bit value on
//   load, decodes every nibble, applies leading-zero blanking, per-digit
//   blinking and a live global enable, and presents the result two ways:
//   static per-digit segments (hex_out) and a time-multiplexed scan output
//   (scan_seg + scan_an). All outputs are registered.
//
//   Parameters:
//     NUM_DIGITS : digit count, 1..8
//     SCAN_DIV   : cycles each digit is held on the scan output, >= 1
//     BLINK_DIV  : cycles per blink half-period, >= 1
//   Ports:
//     clk        : input  system clock
//     rst        : input  synchronous active-high reset
//     load       : input  latch data / lz_blank / blink_mask this edge
//     data       : input  packed value, digit i at [4i+3:4i], digit 0 rightmost
//     lz_blank   : input  leading-zero blanking mode (latched with load)
//     blink_mask : input  per-digit blink enable (latched with load)
//     en         : input  live enable; 0 blanks every output
//     hex_out    : output static active-low segments, digit i at [7i+6:7i]
//     scan_seg   : output active-low segments of the selected digit
//     scan_an    : output active-low one-hot digit select
//
//   Timing: a load sampled at edge k is visible on the outputs after edge
//   k+1; en, scan position and blink phase likewise act one edge later
//   because every output goes through the output register. scan_an and
//   scan_seg come from the same register stage so they never disagree.
// ---------------------------------------------------------------------------
module seven_segment_display_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   data,
  input  logic                      lz_blank,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  input  logic                      en,
  output logic [7*NUM_DIGITS-1:0]   hex_out,
  output logic [6:0]                scan_seg,
  output logic [NUM_DIGITS-1:0]     scan_an
);

  localparam int SCAN_W  = cnt_width(SCAN_DIV);
  localparam int BLINK_W = cnt_width(BLINK_DIV);
  localparam int IDX_W   = cnt_width(NUM_DIGITS);

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic                    lz_q, lz_d;
  logic [NUM_DIGITS-1:0]   blink_q, blink_d;

  logic [SCAN_W-1:0]       scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]        scan_idx_q, scan_idx_d;
  logic [BLINK_W-1:0]      blink_cnt_q, blink_cnt_d;
  logic                    blink_ph_q, blink_ph_d;

  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
  seg_t                    scan_seg_q, scan_seg_d;
  logic [NUM_DIGITS-1:0]   scan_an_q, scan_an_d;

  // -------------------------------------------------------------------------
  // Per-digit decode of the latched value
  // -------------------------------------------------------------------------
  seg_t dec_seg [NUM_DIGITS];
  seg_t vis_seg [NUM_DIGITS];

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    hex_digit_decoder u_dec (
      .nibble (value_q[4*g +: 4]),
      .seg    (dec_seg[g])
    );
  end

  // -------------------------------------------------------------------------
  // Latched inputs and free-running counters
  // -------------------------------------------------------------------------
  always_comb begin
    value_d = value_q;
    lz_d    = lz_q;
    blink_d = blink_q;
    if (load) begin
      value_d = data;
      lz_d    = lz_blank;
      blink_d = blink_mask;
    end

    // Scanner: hold each digit SCAN_DIV cycles, then step to the next one.
    scan_cnt_d = scan_cnt_q + 1'b1;
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
    end

    // Blink phase flips once per BLINK_DIV cycles.
    blink_cnt_d = blink_cnt_q + 1'b1;
    blink_ph_d  = blink_ph_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_ph_d  = ~blink_ph_q;
    end
  end

  // -------------------------------------------------------------------------
  // Visibility: enable, leading-zero blanking and blink-off phase
  // -------------------------------------------------------------------------
  logic nz_seen;

  always_comb begin
    nz_seen = 1'b0;
    hex_d   = '0;
    // Walk from the most significant digit down; a digit is a leading zero
    // while no non-zero nibble has been seen at or above it. Digit 0 is
    // exempt so a value of zero still shows a single "0".
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (value_q[4*i +: 4] != 4'h0) nz_seen = 1'b1;
      if (en && !(lz_q && !nz_seen && (i != 0)) && !(blink_ph_q && blink_q[i]))
        vis_seg[i] = dec_seg[i];
      else
        vis_seg[i] = SEG_BLANK;
      hex_d[7*i +: 7] = vis_seg[i];
    end
  end

  // -------------------------------------------------------------------------
  // Scan mux: select and segment data are built from the same scan_idx_q so
  // they land in the output register on the same edge.
  // -------------------------------------------------------------------------
  always_comb begin
    scan_seg_d = SEG_BLANK;
    scan_an_d  = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx_q == IDX_W'(i)) begin
        scan_seg_d = vis_seg[i];
        if (en) scan_an_d[i] = 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q     <= '0;
      lz_q        <= 1'b0;
      blink_q     <= '0;
      scan_cnt_q  <= '0;
      scan_idx_q  <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      hex_q       <= '1;
      scan_seg_q  <= SEG_BLANK;
      scan_an_q   <= '1;
    end else begin
      value_q     <= value_d;
      lz_q        <= lz_d;
      blink_q     <= blink_d;
      scan_cnt_q  <= scan_cnt_d;
      scan_idx_q  <= scan_idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      hex_q       <= hex_d;
      scan_seg_q  <= scan_seg_d;
      scan_an_q   <= scan_an_d;
    end
  end

  assign hex_out  = hex_q;
  assign scan_seg = scan_seg_q;
  assign scan_an  = scan_an_q;

endmodule

// File: tb/tb_seven_segment_display_driver.sv
// ---------------------------------------------------------------------------
// tb_seven_segment_display_driver
//   Bench for a 4-digit instance with SCAN_DIV=4 and BLINK_DIV=8.
//   A reference model works from "cycles since reset" with plain arithmetic
//   (scan digit = t/4 mod 4, blink phase = t/8 mod 2) and pushes the expected
//   registered outputs into exp_q on every rising edge; the scoreboard pops
//   and compares on the falling edge. Directed steps add fixed-value checks.
// ---------------------------------------------------------------------------
module tb_seven_segment_display_driver;

  localparam int ND  = 4;
  localparam int SD  = 4;
  localparam int BD  = 8;
  localparam int EW  = 7*ND + 7 + ND;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [15:0]   data;
  logic          lz_blank;
  logic [3:0]    blink_mask;
  logic          en;
  logic [27:0]   hex_out;
  logic [6:0]    scan_seg;
  logic [3:0]    scan_an;

  always #5 clk = ~clk;

  seven_segment_display_driver #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD),
    .BLINK_DIV  (BD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data       (data),
    .lz_blank   (lz_blank),
    .blink_mask (blink_mask),
    .en         (en),
    .hex_out    (hex_out),
    .scan_seg   (scan_seg),
    .scan_an    (scan_an)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Outputs produced after a rising edge, given the latched state and the
  // number t of edges counted since reset before that edge.
  function automatic logic [EW-1:0] model_out(input logic [15:0] val, input logic lz,
                                              input logic [3:0] bm, input int t,
                                              input logic e);
    logic [6:0] segs [4];
    int ph;
    int idx;
    int v;
    logic [3:0] an;
    ph  = (t / BD) % 2;
    idx = (t / SD) % ND;
    v   = int'(val);
    for (int i = 0; i < ND; i++) begin
      int  nib;
      bit  vis;
      nib = (v >> (4*i)) & 15;
      vis = e && !(lz && i > 0 && ((v >> (4*i)) == 0)) && !(ph == 1 && bm[i]);
      segs[i] = vis ? glyph[nib] : 7'h7F;
    end
    an = 4'hF;
    if (e) an[idx] = 1'b0;
    return {segs[3], segs[2], segs[1], segs[0], segs[idx], an};
  endfunction

  logic [15:0]      m_val;
  logic             m_lz;
  logic [3:0]       m_bm;
  int               m_t;
  logic [EW-1:0]    exp_q [$];

  always @(posedge clk) begin
    if (rst) begin
      m_val = '0;
      m_lz  = 1'b0;
      m_bm  = '0;
      m_t   = 0;
      exp_q.push_back({28'hFFFFFFF, 7'h7F, 4'hF});
    end else begin
      exp_q.push_back(model_out(m_val, m_lz, m_bm, m_t, en));
      if (load) begin
        m_val = data;
        m_lz  = lz_blank;
        m_bm  = blink_mask;
      end
      m_t++;
    end
  end

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_hex_out",  64'(hex_out),  64'(e[EW-1 -: 28]));
      check("sb_scan_seg", 64'(scan_seg), 64'(e[10:4]));
      check("sb_scan_an",  64'(scan_an),  64'(e[3:0]));
    end
  end

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] d, input logic lz, input logic [3:0] bm);
    load = 1'b1; data = d; lz_blank = lz; blink_mask = bm;
    cycles(1);
    load = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    int cnt_e, cnt_d, cnt_b, cnt_7, blank0, blank1;

    rst = 1'b1; load = 1'b0; data = '0; lz_blank = 1'b0; blink_mask = '0; en = 1'b1;
    cycles(2);

    // Reset state, also the "before load" view.
    check("rst_hex_out",  64'(hex_out),  64'h0FFFFFFF);
    check("rst_scan_seg", 64'(scan_seg), 64'h7F);
    check("rst_scan_an",  64'(scan_an),  64'hF);

    // Load 1234 straight out of reset: visible two edges after presentation.
    rst = 1'b0;
    do_load(16'h1234, 1'b0, 4'b0000);
    cycles(1);
    check("load_1234", 64'(hex_out), 64'({7'h79, 7'h24, 7'h30, 7'h19}));

    // Leading-zero blanking.
    do_load(16'h00A0, 1'b1, 4'b0000);
    cycles(1);
    check("lz_00A0", 64'(hex_out), 64'({7'h7F, 7'h7F, 7'h08, 7'h40}));
    do_load(16'h0000, 1'b1, 4'b0000);
    cycles(1);
    check("lz_0000", 64'(hex_out), 64'({7'h7F, 7'h7F, 7'h7F, 7'h40}));

    // Scan: over 16 cycles each select code appears exactly 4 times.
    do_load(16'h1234, 1'b0, 4'b0000);
    cycles(1);
    cnt_e = 0; cnt_d = 0; cnt_b = 0; cnt_7 = 0;
    for (int i = 0; i < 16; i++) begin
      cycles(1);
      case (scan_an)
        4'hE: cnt_e++;
        4'hD: cnt_d++;
        4'hB: cnt_b++;
        4'h7: cnt_7++;
        default: ;
      endcase
    end
    check("scan_cnt_E", 64'(cnt_e), 64'd4);
    check("scan_cnt_D", 64'(cnt_d), 64'd4);
    check("scan_cnt_B", 64'(cnt_b), 64'd4);
    check("scan_cnt_7", 64'(cnt_7), 64'd4);

    // Blink digit 0: half of any 16-cycle window blank, digit 1 steady.
    do_load(16'h1234, 1'b0, 4'b0001);
    cycles(1);
    blank0 = 0; blank1 = 0;
    for (int i = 0; i < 32; i++) begin
      cycles(1);
      if (hex_out[6:0]  == 7'h7F) blank0++;
      if (hex_out[13:7] == 7'h7F) blank1++;
    end
    check("blink_d0_blank", 64'(blank0), 64'd16);
    check("blink_d1_blank", 64'(blank1), 64'd0);

    // Enable off mid-scan, then back on; the model tracks the scan position.
    cycles(2);
    en = 1'b0;
    cycles(1);
    check("en0_hex_out",  64'(hex_out),  64'h0FFFFFFF);
    check("en0_scan_seg", 64'(scan_seg), 64'h7F);
    check("en0_scan_an",  64'(scan_an),  64'hF);
    cycles(5);
    en = 1'b1;
    cycles(10);

    // Reset beats a simultaneous load.
    rst = 1'b1; load = 1'b1; data = 16'hFFFF; lz_blank = 1'b0; blink_mask = 4'b0000;
    cycles(1);
    check("rstld_hex_out",  64'(hex_out),  64'h0FFFFFFF);
    check("rstld_scan_seg", 64'(scan_seg), 64'h7F);
    check("rstld_scan_an",  64'(scan_an),  64'hF);
    rst = 1'b0; load = 1'b0;
    cycles(1);
    check("rstld_zero", 64'(hex_out), 64'({7'h40, 7'h40, 7'h40, 7'h40}));
    check("rstld_an",   64'(scan_an), 64'hE);

    // Randomized traffic, including back-to-back loads and occasional reset.
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 99) == 0);
      load       = ($urandom_range(0, 3) == 0);
      data       = 16'($urandom);
      if ($urandom_range(0, 1) == 1) data = data & 16'h00FF;
      if ($urandom_range(0, 3) == 0) data = data & 16'h000F;
      lz_blank   = 1'($urandom_range(0, 1));
      blink_mask = 4'($urandom);
      en         = ($urandom_range(0, 7) != 0);
      cycles(1);
    end

    rst = 1'b0; load = 1'b0; en = 1'b1;
    cycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
